modbus_tx_framer: RTL and testbench

MODBUS_TX_FRAMER -- requirements
Module: modbus_tx_framer

---
 rtl/modbus_tx_framer_if.sv | 33 +++
 rtl/modbus_tx_framer.sv | 192 +++++++++++++++++++
 tb/tb_modbus_tx_framer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_tx_framer_if.sv
// modbus_tx_framer_if: request, read-buffer and UART byte-stream signals of the Modbus response framer.
// Revision: 1.0
`default_nettype none

interface modbus_tx_framer_if;
  logic        handler_done;
  logic [7:0]  func_code_r;
  logic [15:0] addr_r;
  logic [15:0] data_r;
  logic [7:0]  tx_quantity;
  logic [7:0]  exception_out;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        tx_frame_done;

  modport master (
    input  handler_done, func_code_r, addr_r, data_r, tx_quantity, exception_out,
    input  dpram_rdata, tx_ready,
    output dpram_raddr, tx_data, tx_valid, busy, tx_frame_done
  );

  modport slave (
    output handler_done, func_code_r, addr_r, data_r, tx_quantity, exception_out,
    output dpram_rdata, tx_ready,
    input  dpram_raddr, tx_data, tx_valid, busy, tx_frame_done
  );
endinterface

`default_nettype wire

// File: rtl/modbus_tx_framer.sv
// modbus_tx_framer: serialises a Modbus RTU response (normal, echo or exception) with CRC-16/MODBUS.
// Revision: 1.0
`default_nettype none

module modbus_tx_framer #(
  parameter logic [7:0] SADDR = 8'h01
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  modbus_tx_framer_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, HDR_ADDR, HDR_FUNC, EXC, COUNT, RD, RD_WAIT,
    DATA_HI, DATA_LO, ECHO, CRC_LO, CRC_HI, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  func_q, qty_q, exc_q;
  logic [15:0] addr_q, data_q;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [15:0] word_q, word_d;
  logic [15:0] crc_q, crc_d;

  logic        w_read_fn, w_echo_fn, w_unsup;
  logic [7:0]  w_exc_code;
  logic        w_tx_valid, w_done, w_busy;
  logic [7:0]  w_tx_data;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign w_read_fn  = (func_q == 8'h03) || (func_q == 8'h04);
  assign w_echo_fn  = (func_q == 8'h06);
  // An over-long read is reported as an illegal-data-value exception.
  assign w_exc_code = (exc_q != 8'h00) ? exc_q :
                      (w_read_fn && (qty_q > 8'd125)) ? 8'h03 : 8'h00;
  assign w_unsup    = (w_exc_code == 8'h00) && !w_read_fn && !w_echo_fn;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    crc_d      = crc_q;
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    w_done     = 1'b0;
    w_busy     = (state_q != IDLE) && (state_q != DONE);

    case (state_q)
      IDLE: begin
        if (bus.handler_done) begin
          state_d    = HDR_ADDR;
          crc_d      = 16'hFFFF;
          word_cnt_d = 8'h00;
          byte_cnt_d = 8'h00;
        end
      end
      HDR_ADDR: begin
        if (w_unsup) begin
          state_d = IDLE;
        end else begin
          w_tx_valid = 1'b1;
          w_tx_data  = SADDR;
          if (bus.tx_ready) state_d = HDR_FUNC;
        end
      end
      HDR_FUNC: begin
        w_tx_valid = 1'b1;
        w_tx_data  = (w_exc_code != 8'h00) ? (func_q | 8'h80) : func_q;
        if (bus.tx_ready) begin
          if (w_exc_code != 8'h00) state_d = EXC;
          else if (w_echo_fn)      state_d = ECHO;
          else                     state_d = COUNT;
        end
      end
      EXC: begin
        w_tx_valid = 1'b1;
        w_tx_data  = w_exc_code;
        if (bus.tx_ready) state_d = CRC_LO;
      end
      COUNT: begin
        w_tx_valid = 1'b1;
        w_tx_data  = {qty_q[6:0], 1'b0};
        if (bus.tx_ready) state_d = (qty_q == 8'h00) ? CRC_LO : RD;
      end
      RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        word_d  = bus.dpram_rdata;
        state_d = DATA_HI;
      end
      DATA_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = word_q[15:8];
        if (bus.tx_ready) state_d = DATA_LO;
      end
      DATA_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = word_q[7:0];
        if (bus.tx_ready) begin
          if (word_cnt_q + 8'd1 == qty_q) begin
            state_d = CRC_LO;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
            state_d    = RD;
          end
        end
      end
      ECHO: begin
        w_tx_valid = 1'b1;
        case (byte_cnt_q[1:0])
          2'd0:    w_tx_data = addr_q[15:8];
          2'd1:    w_tx_data = addr_q[7:0];
          2'd2:    w_tx_data = data_q[15:8];
          default: w_tx_data = data_q[7:0];
        endcase
        if (bus.tx_ready) begin
          if (byte_cnt_q == 8'd3) state_d = CRC_LO;
          else                    byte_cnt_d = byte_cnt_q + 8'd1;
        end
      end
      CRC_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = crc_q[7:0];
        if (bus.tx_ready) state_d = CRC_HI;
      end
      CRC_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = crc_q[15:8];
        if (bus.tx_ready) state_d = DONE;
      end
      DONE: begin
        w_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_tx_valid && bus.tx_ready && (state_q != CRC_LO) && (state_q != CRC_HI)) begin
      crc_d = crc16_update(crc_q, w_tx_data);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      func_q     <= 8'h00;
      qty_q      <= 8'h00;
      exc_q      <= 8'h00;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      byte_cnt_q <= 8'h00;
      word_cnt_q <= 8'h00;
      word_q     <= 16'h0000;
      crc_q      <= 16'hFFFF;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      crc_q      <= crc_d;
      if ((state_q == IDLE) && bus.handler_done) begin
        func_q <= bus.func_code_r;
        qty_q  <= bus.tx_quantity;
        exc_q  <= bus.exception_out;
        addr_q <= bus.addr_r;
        data_q <= bus.data_r;
      end
    end
  end

  assign bus.dpram_raddr   = word_cnt_q;
  assign bus.tx_data       = w_tx_data;
  assign bus.tx_valid      = w_tx_valid;
  assign bus.busy          = w_busy;
  assign bus.tx_frame_done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_modbus_tx_framer.sv
// tb_modbus_tx_framer: directed and randomised response frames checked against a frame-building reference model.
// Revision: 1.0
`default_nettype none

module tb_modbus_tx_framer;
  localparam logic [7:0] SADDR = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modbus_tx_framer_if bus();

  modbus_tx_framer #(.SADDR(SADDR)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.master)
  );

  logic [15:0] mem [0:255];
  always_ff @(posedge clk) bus.dpram_rdata <= mem[bus.dpram_raddr];

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ra_q[$];
  int seen_valid;
  int done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic [7:0]  v;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = exp_q[i];
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ v[b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic build_model(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] qn, input logic [7:0] ex);
    logic [15:0] crc;
    logic [15:0] w;
    exp_q.delete();
    if (ex != 8'h00) begin
      exp_q.push_back(SADDR); exp_q.push_back(f | 8'h80); exp_q.push_back(ex);
    end else if (f == 8'h03 || f == 8'h04) begin
      if (qn > 8'd125) begin
        exp_q.push_back(SADDR); exp_q.push_back(f | 8'h80); exp_q.push_back(8'h03);
      end else begin
        exp_q.push_back(SADDR); exp_q.push_back(f); exp_q.push_back(8'(2 * int'(qn)));
        for (int i = 0; i < int'(qn); i++) begin
          w = mem[i];
          exp_q.push_back(w[15:8]);
          exp_q.push_back(w[7:0]);
        end
      end
    end else if (f == 8'h06) begin
      exp_q.push_back(SADDR); exp_q.push_back(8'h06);
      exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
      exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
    end
    if (exp_q.size() != 0) begin
      crc = crc_ref();
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
  endtask

  task automatic request(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] qn, input logic [7:0] ex);
    @(posedge clk); #1;
    bus.func_code_r   = f;
    bus.addr_r        = a;
    bus.data_r        = d;
    bus.tx_quantity   = qn;
    bus.exception_out = ex;
    bus.handler_done  = 1'b1;
    @(posedge clk); #1;
    bus.handler_done  = 1'b0;
    bus.func_code_r   = 8'($urandom);
    bus.addr_r        = 16'($urandom);
    bus.data_r        = 16'($urandom);
    bus.tx_quantity   = 8'($urandom);
    bus.exception_out = 8'($urandom);
  endtask

  task automatic capture(input int stall_pct, input int max_bytes, input int budget);
    logic       stalled;
    logic [7:0] prev;
    got_q.delete();
    ra_q.delete();
    seen_valid = 0;
    done_seen  = 0;
    stalled    = 1'b0;
    prev       = 8'h00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (bus.busy && (ra_q.size() == 0 || ra_q[ra_q.size()-1] != bus.dpram_raddr))
        ra_q.push_back(bus.dpram_raddr);
      if (stalled) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'(prev));
      end
      if (bus.tx_valid) seen_valid = 1;
      stalled = bus.tx_valid && !bus.tx_ready;
      prev    = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        if (max_bytes > 0 && got_q.size() == max_bytes) begin
          @(posedge clk);
          return;
        end
      end
      if (bus.tx_frame_done) begin
        done_seen = 1;
        @(posedge clk); #1;
        check("done_pulse_width", 32'(bus.tx_frame_done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        return;
      end
      @(posedge clk); #1;
      bus.tx_ready = ($urandom_range(99) >= stall_pct);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    logic [7:0]  f, qn, ex;
    logic [15:0] a, d;
    int          sp;

    bus.handler_done  = 1'b0;
    bus.func_code_r   = 8'h00;
    bus.addr_r        = 16'h0000;
    bus.data_r        = 16'h0000;
    bus.tx_quantity   = 8'h00;
    bus.exception_out = 8'h00;
    bus.tx_ready      = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_raddr", 32'(bus.dpram_raddr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_done", 32'(bus.tx_frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Exception frame
    bus.tx_ready = 1'b1;
    request(8'h03, 16'h0000, 16'h0000, 8'd4, 8'h02);
    capture(0, 0, 100);
    exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    check_frame("exc");

    // Echo frame
    request(8'h06, 16'h0001, 16'h0003, 8'd1, 8'h00);
    capture(0, 0, 100);
    exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    check_frame("echo");

    // Read of four words
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    request(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
    capture(0, 0, 200);
    build_model(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
    check_frame("read");
    check("read_count_byte", 32'(got_q.size() > 2 ? got_q[2] : 8'hEE), 32'h08);
    check("raddr_len", 32'(ra_q.size()), 32'd4);
    for (int i = 0; i < ra_q.size() && i < 4; i++) check("raddr_seq", 32'(ra_q[i]), 32'(i));

    // Same read under random backpressure
    request(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
    capture(50, 0, 400);
    check_frame("read_bp");
    bus.tx_ready = 1'b1;

    // Quantity limits
    request(8'h03, 16'h0000, 16'h0000, 8'd126, 8'h00);
    capture(0, 0, 100);
    build_model(8'h03, 16'h0000, 16'h0000, 8'd126, 8'h00);
    check_frame("qty126");
    request(8'h04, 16'h0000, 16'h0000, 8'd0, 8'h00);
    capture(0, 0, 100);
    build_model(8'h04, 16'h0000, 16'h0000, 8'd0, 8'h00);
    check_frame("qty0");

    // Unsupported function code
    request(8'h05, 16'h1234, 16'h5678, 8'd3, 8'h00);
    capture(0, 0, 20);
    check("unsup_valid", 32'(seen_valid), 32'd0);
    check("unsup_done", 32'(done_seen), 32'd0);
    check("unsup_busy", 32'(bus.busy), 32'd0);

    // Randomised frames
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      case ($urandom_range(2))
        0:       f = 8'h03;
        1:       f = 8'h04;
        default: f = 8'h06;
      endcase
      qn = ($urandom_range(3) == 0) ? 8'($urandom_range(124, 127)) : 8'($urandom_range(0, 12));
      ex = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      a  = 16'($urandom);
      d  = 16'($urandom);
      sp = $urandom_range(0, 60);
      bus.tx_ready = 1'b1;
      request(f, a, d, qn, ex);
      capture(sp, 0, 2000);
      build_model(f, a, d, qn, ex);
      check_frame("rand");
    end
    bus.tx_ready = 1'b1;

    // Reset mid-frame, then immediate restart
    request(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
    capture(0, 3, 50);
    check("pre_rst_bytes", 32'(got_q.size()), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(bus.tx_valid), 32'd0);
    rst                = 1'b0;
    bus.func_code_r    = 8'h06;
    bus.addr_r         = 16'hBEEF;
    bus.data_r         = 16'h0042;
    bus.tx_quantity    = 8'd0;
    bus.exception_out  = 8'h00;
    bus.handler_done   = 1'b1;
    @(posedge clk); #1;
    bus.handler_done   = 1'b0;
    check("restart_busy", 32'(bus.busy), 32'd1);
    capture(0, 0, 100);
    build_model(8'h06, 16'hBEEF, 16'h0042, 8'd0, 8'h00);
    check_frame("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
